dmx4_frame: RTL and testbench
=============================

# dmx4_frame

Registered 1-to-4 demultiplexer with frame tracking: the receive-side counterpart of the 4:1 selection path in the shifter datapath. One WIDTH-bit input word per accepted cycle is steered to one of four output registers. The target register is chosen either by an explicit 2-bit select or by an internal round-robin pointer. The block tracks which channels have been loaded and pulses when all four hold fresh data, so downstream logic can consume a complete 4-word frame.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- i_valid  input  1  accept i_data this cycle
- i_data  input  WIDTH  word to steer
- i_sel  input  2  target channel when i_mode=0
- i_mode  input  1  0 = explicit select, 1 = round-robin
- i_clear  input  1  synchronous frame clear
- o_d0..o_d3  output  WIDTH each  channel data registers
- o_valid  output  4  per-channel one-cycle load strobe
- o_full  output  1  all four channels loaded since last frame start
- o_frame  output  1  one-cycle pulse on completion of a frame
- o_ptr  output  2  current round-robin pointer

## Operation
- Target channel is i_sel when i_mode=0, and o_ptr when i_mode=1.
- Accepted write (i_valid=1, i_clear=0):
  - o_d[target] <= i_data
  - o_valid[target] <= 1; all other o_valid bits <= 0
- Round-robin pointer:
  - Advances by 1 mod 4 (3→0 wrap) only on an accepted write in mode 1.
  - Holds in mode 0.
  - Retained across mode changes.
- Load mask: a 4-bit internal register, one bit per channel.
- FSM states:
  - EMPTY: mask=0.
  - PARTIAL: 0 < mask < 4'b1111.
  - FULL: mask=4'b1111.
- FSM transitions:
  - EMPTY/PARTIAL + write → mask |= onehot(target). Go to FULL if the mask becomes all ones, else PARTIAL.
  - Rewriting an already-loaded channel in PARTIAL overwrites the data; the mask is unchanged.
  - FULL + write → mask = onehot(target), go to PARTIAL (a new frame starts).
  - FULL + no write → stay in FULL.
  - i_clear=1 from any state → EMPTY, mask=0, o_ptr=0, o_valid=0. Data registers hold their values.
  - i_clear and i_valid asserted together: clear wins and the write is dropped.
- Outputs from state:
  - o_full = (state == FULL).
  - o_frame = 1 only on the cycle the FSM enters FULL.

## Timing
- Reset (reset_n=0, asynchronous): o_d0..o_d3=0, o_valid=0, o_full=0, o_frame=0, o_ptr=0, state EMPTY.
- Reset asserted mid-frame discards partial progress immediately, without waiting for a clock edge.
- Write latency is 1 cycle. An accepted write at edge k updates o_dX, o_valid, o_frame, o_full and o_ptr visibly after edge k.
- o_valid and o_frame are single-cycle strobes. They deassert on the following edge unless another write occurs.
- On the completing write, o_frame and the final o_valid bit assert in the same cycle.
- No backpressure: every i_valid cycle is accepted unless i_clear is high.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Shared header holds:
  - state encodings: ST_EMPTY=2'd0, ST_PARTIAL=2'd1, ST_FULL=2'd2
  - mode constants: MODE_SEL=1'b0, MODE_RR=1'b1
- Sub-module dmx4: combinational 1-to-4 decoder, inputs en and s[1:0], output 4-bit one-hot. It drives both the register enables and the mask update.
- Top level contains the pointer counter, mask register, FSM and data registers.

## Test plan
- Reset: hold reset_n=0 → all outputs 0 and o_ptr=0. Release reset → no strobes appear.
- Explicit select: mode 0, write sel=2 data 0xA5 → next cycle o_d2=0xA5, o_valid=4'b0100, o_full=0, o_ptr=0.
- Round-robin frame: mode 1, write 0x11, 0x22, 0x33, 0x44 on consecutive cycles → o_d0..o_d3 = 0x11..0x44. After the 4th write: o_frame=1 for one cycle, o_full stays 1, o_ptr wraps to 0. A 5th write 0x55 → o_d0=0x55, o_full=0, state PARTIAL.
- Overwrite: mode 0, write sel=1 twice, then sel 0, 2, 3 → o_frame pulses only after the sel=3 write, and o_d1 holds the second value.
- Clear collision: in PARTIAL, assert i_clear and i_valid together → data unchanged, o_valid=0, mask cleared, o_ptr=0.
- Async reset mid-frame: after 2 round-robin writes, pulse reset_n between clock edges → outputs zero immediately. A following 4-write frame completes normally starting at channel 0.

Source files
------------

// File: rtl/dmx4_frame_pkg.sv
// rtl/dmx4_frame_pkg.sv - shared state and mode encodings for the 1-to-4 frame demultiplexer
package dmx4_frame_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    localparam logic [3:0] MASK_ALL = 4'b1111;

endpackage

// File: rtl/dmx4.sv
// rtl/dmx4.sv - combinational enabled 2-to-4 one-hot decoder
module dmx4 (
    input  logic       en,
    input  logic [1:0] s,
    output logic [3:0] y
);

    always_comb begin
        y = 4'b0000;
        if (en) begin
            y[s] = 1'b1;
        end
    end

endmodule

// File: rtl/dmx4_frame.sv
// rtl/dmx4_frame.sv - registered 1-to-4 demux with round-robin pointer and frame completion tracking
module dmx4_frame
    import dmx4_frame_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_sel,
    input  logic             i_mode,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_d0,
    output logic [WIDTH-1:0] o_d1,
    output logic [WIDTH-1:0] o_d2,
    output logic [WIDTH-1:0] o_d3,
    output logic [3:0]       o_valid,
    output logic             o_full,
    output logic             o_frame,
    output logic [1:0]       o_ptr
);

    state_t     state;
    state_t     state_next;
    logic [3:0] mask;
    logic [3:0] mask_next;
    logic       frame_next;
    logic       wr;
    logic [1:0] target;
    logic [3:0] load_1h;

    // Clear takes priority, so a colliding write never reaches the decoder.
    assign wr     = i_valid & ~i_clear;
    assign target = (i_mode == MODE_SEL) ? i_sel : o_ptr;

    dmx4 u_dmx4 (
        .en (wr),
        .s  (target),
        .y  (load_1h)
    );

    always_comb begin
        state_next = state;
        mask_next  = mask;
        frame_next = 1'b0;
        if (i_clear) begin
            state_next = ST_EMPTY;
            mask_next  = 4'b0000;
        end else if (wr) begin
            case (state)
                ST_FULL: begin
                    mask_next  = load_1h;
                    state_next = ST_PARTIAL;
                end
                default: begin
                    mask_next  = mask | load_1h;
                    state_next = (mask_next == MASK_ALL) ? ST_FULL : ST_PARTIAL;
                    frame_next = (mask_next == MASK_ALL);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_EMPTY;
            mask    <= 4'b0000;
            o_frame <= 1'b0;
            o_valid <= 4'b0000;
            o_ptr   <= 2'd0;
        end else begin
            state   <= state_next;
            mask    <= mask_next;
            o_frame <= frame_next;
            o_valid <= load_1h;
            if (i_clear) begin
                o_ptr <= 2'd0;
            end else if (wr && (i_mode == MODE_RR)) begin
                o_ptr <= o_ptr + 2'd1;
            end
        end
    end

    // Data registers are left untouched by clear; only reset zeroes them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_d0 <= '0;
            o_d1 <= '0;
            o_d2 <= '0;
            o_d3 <= '0;
        end else begin
            if (load_1h[0]) o_d0 <= i_data;
            if (load_1h[1]) o_d1 <= i_data;
            if (load_1h[2]) o_d2 <= i_data;
            if (load_1h[3]) o_d3 <= i_data;
        end
    end

    assign o_full = (state == ST_FULL);

endmodule

// File: tb/tb_dmx4_frame.sv
// tb/tb_dmx4_frame.sv - directed self-checking bench for dmx4_frame
module tb_dmx4_frame;

    logic       clk;
    logic       reset_n;
    logic       i_valid;
    logic [7:0] i_data;
    logic [1:0] i_sel;
    logic       i_mode;
    logic       i_clear;
    logic [7:0] o_d0;
    logic [7:0] o_d1;
    logic [7:0] o_d2;
    logic [7:0] o_d3;
    logic [3:0] o_valid;
    logic       o_full;
    logic       o_frame;
    logic [1:0] o_ptr;

    int tests_run;
    int tests_failed;

    dmx4_frame #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_sel   (i_sel),
        .i_mode  (i_mode),
        .i_clear (i_clear),
        .o_d0    (o_d0),
        .o_d1    (o_d1),
        .o_d2    (o_d2),
        .o_d3    (o_d3),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_frame (o_frame),
        .o_ptr   (o_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic m, input logic [1:0] s,
                        input logic [7:0] d, input logic c);
        i_valid = v;
        i_mode  = m;
        i_sel   = s;
        i_data  = d;
        i_clear = c;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_clear = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n = 1'b0;
        i_valid = 1'b0;
        i_data  = 8'h00;
        i_sel   = 2'd0;
        i_mode  = 1'b0;
        i_clear = 1'b0;

        #3;
        chk("reset_d", {o_d0, o_d1, o_d2, o_d3}, 32'h0);
        chk("reset_valid", {28'h0, o_valid}, 32'h0);
        chk("reset_flags", {29'h0, o_full, o_frame, 1'b0}, 32'h0);
        chk("reset_ptr", {30'h0, o_ptr}, 32'h0);
        #9 reset_n = 1'b1;

        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
        chk("post_reset_strobes", {27'h0, o_valid, o_frame}, 32'h0);

        // explicit select
        step(1'b1, 1'b0, 2'd2, 8'hA5, 1'b0);
        chk("sel_d2", {24'h0, o_d2}, 32'hA5);
        chk("sel_valid", {28'h0, o_valid}, 32'h4);
        chk("sel_full", {31'h0, o_full}, 32'h0);
        chk("sel_ptr", {30'h0, o_ptr}, 32'h0);
        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
        chk("sel_strobe_drop", {28'h0, o_valid}, 32'h0);
        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);

        // round-robin frame
        step(1'b1, 1'b1, 2'd3, 8'h11, 1'b0);
        chk("rr1_valid", {28'h0, o_valid}, 32'h1);
        chk("rr1_ptr", {30'h0, o_ptr}, 32'h1);
        step(1'b1, 1'b1, 2'd3, 8'h22, 1'b0);
        chk("rr2_ptr", {30'h0, o_ptr}, 32'h2);
        step(1'b1, 1'b1, 2'd3, 8'h33, 1'b0);
        chk("rr3_frame", {30'h0, o_full, o_frame}, 32'h0);
        step(1'b1, 1'b1, 2'd3, 8'h44, 1'b0);
        chk("rr4_data", {o_d0, o_d1, o_d2, o_d3}, 32'h11223344);
        chk("rr4_valid", {28'h0, o_valid}, 32'h8);
        chk("rr4_frame_full", {30'h0, o_full, o_frame}, 32'h3);
        chk("rr4_ptr_wrap", {30'h0, o_ptr}, 32'h0);
        step(1'b0, 1'b1, 2'd0, 8'h00, 1'b0);
        chk("rr_idle_frame_full", {30'h0, o_full, o_frame}, 32'h2);
        chk("rr_idle_valid", {28'h0, o_valid}, 32'h0);
        step(1'b1, 1'b1, 2'd0, 8'h55, 1'b0);
        chk("rr5_d0", {24'h0, o_d0}, 32'h55);
        chk("rr5_full_frame", {30'h0, o_full, o_frame}, 32'h0);
        chk("rr5_ptr", {30'h0, o_ptr}, 32'h1);

        // overwrite in PARTIAL
        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
        chk("clr_ptr", {30'h0, o_ptr}, 32'h0);
        step(1'b1, 1'b0, 2'd1, 8'h61, 1'b0);
        step(1'b1, 1'b0, 2'd1, 8'h62, 1'b0);
        chk("ow_rewrite_frame", {31'h0, o_frame}, 32'h0);
        step(1'b1, 1'b0, 2'd0, 8'h70, 1'b0);
        step(1'b1, 1'b0, 2'd2, 8'h72, 1'b0);
        chk("ow_three_frame", {30'h0, o_full, o_frame}, 32'h0);
        step(1'b1, 1'b0, 2'd3, 8'h73, 1'b0);
        chk("ow_complete", {30'h0, o_full, o_frame}, 32'h3);
        chk("ow_data", {o_d0, o_d1, o_d2, o_d3}, 32'h70627273);
        chk("ow_ptr_hold", {30'h0, o_ptr}, 32'h0);

        // clear collides with a write
        step(1'b1, 1'b1, 2'd0, 8'h90, 1'b0);
        chk("pre_clr_ptr", {30'h0, o_ptr}, 32'h1);
        step(1'b1, 1'b1, 2'd0, 8'hEE, 1'b1);
        chk("coll_data", {o_d0, o_d1, o_d2, o_d3}, 32'h90627273);
        chk("coll_valid", {28'h0, o_valid}, 32'h0);
        chk("coll_ptr", {30'h0, o_ptr}, 32'h0);
        chk("coll_full", {30'h0, o_full, o_frame}, 32'h0);
        // mask must really be empty: three writes cannot complete a frame
        step(1'b1, 1'b0, 2'd1, 8'h01, 1'b0);
        step(1'b1, 1'b0, 2'd2, 8'h02, 1'b0);
        step(1'b1, 1'b0, 2'd3, 8'h03, 1'b0);
        chk("coll_mask_cleared", {30'h0, o_full, o_frame}, 32'h0);

        // async reset mid-frame
        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 2'd0, 8'hA1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 8'hA2, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_d", {o_d0, o_d1, o_d2, o_d3}, 32'h0);
        chk("arst_ptr_valid", {26'h0, o_ptr, o_valid}, 32'h0);
        #1 reset_n = 1'b1;
        step(1'b1, 1'b1, 2'd0, 8'hB1, 1'b0);
        chk("arst_first_ch0", {28'h0, o_valid}, 32'h1);
        step(1'b1, 1'b1, 2'd0, 8'hB2, 1'b0);
        step(1'b1, 1'b1, 2'd0, 8'hB3, 1'b0);
        chk("arst_three_frame", {31'h0, o_frame}, 32'h0);
        step(1'b1, 1'b1, 2'd0, 8'hB4, 1'b0);
        chk("arst_frame", {30'h0, o_full, o_frame}, 32'h3);
        chk("arst_data", {o_d0, o_d1, o_d2, o_d3}, 32'hB1B2B3B4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
